io_intr_timer_dev: RTL and testbench



---
 rtl/io_intr_timer_dev_if.sv | 28 ++
 rtl/io_intr_timer_dev.sv | 192 +++++++++++++++++++
 tb/tb_io_intr_timer_dev.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_intr_timer_dev_if.sv
// -----------------------------------------------------------------------------
// io_intr_timer_dev_if
//   Bus control group for the IO interrupt/timer peripheral. It carries the
//   word address, the active-low chip select and strobes, and the device
//   enable. The bi-directional Data bus stays a plain inout port on the
//   device so that tristate resolution happens on a single net.
//
//   Handshake: there is no valid/ready pair. A bus cycle is qualified by
//   Enable & !CS_. A read (!RD_) returns data combinationally while it is
//   held. A write (!WR_) is captured on the rising clock edge. The master
//   never asserts RD_ and WR_ together.
//
//   Signals: Addr[ADDR_W] word address, CS_ chip select (low), RD_ read
//   strobe (low), WR_ write strobe (low), Enable device enable (high).
//   Modports: master drives everything; slave observes everything.
// -----------------------------------------------------------------------------
interface io_intr_timer_dev_if #(
  parameter int ADDR_W = 10
) ();
  logic [ADDR_W-1:0] Addr;
  logic              CS_;
  logic              RD_;
  logic              WR_;
  logic              Enable;

  modport master (output Addr, CS_, RD_, WR_, Enable);
  modport slave  (input  Addr, CS_, RD_, WR_, Enable);
endinterface

// File: rtl/io_intr_timer_dev.sv
// -----------------------------------------------------------------------------
// io_intr_timer_dev
//   Memory-mapped IO peripheral. It has a word memory, a small control and
//   status register block, and NCH countdown timers. Each timer raises a
//   fast or a normal interrupt request. The CPU retires requests one at a
//   time with rising edges on int_ack.
//
//   Ports:
//     Clk          system clock, all state updates on posedge
//     Reset        synchronous, active-high reset
//     bus          control group (Addr, CS_, RD_, WR_, Enable), slave side
//     Data         bi-directional data bus, hi-Z unless a read is selected
//     int_ack      interrupt acknowledge; each rising edge retires one request
//     fintr_check  fast interrupt request (registered)
//     intr_check   normal interrupt request (registered)
//
//   Register block (Addr[ADDR_W-1:4] all ones, offset Addr[3:0]):
//     0x0 CTRL    [NCH-1:0] enable, [2NCH-1:NCH] fast select
//     0x1 STATUS  [NCH-1:0] pending, [2NCH-1:NCH] overrun, write-1-to-clear
//     0x2 ACKID   [1:0] last acknowledged channel, [DATA_W-1] valid
//     0x4+ch      RELOAD (RW)       0x8+ch  COUNT (RO)
// -----------------------------------------------------------------------------
module io_intr_timer_dev #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int NCH    = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  io_intr_timer_dev_if.slave    bus,
  inout  wire  [DATA_W-1:0]     Data,
  input  logic                  int_ack,
  output logic                  fintr_check,
  output logic                  intr_check
);

  localparam int MEM_WORDS = (1 << ADDR_W) - 16;

  logic [ADDR_W-1:0] addr;
  logic [3:0]        off;
  logic              is_reg;
  logic              rd_en;
  logic              wr_en;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  assign addr   = bus.Addr;
  assign off    = addr[3:0];
  assign is_reg = &addr[ADDR_W-1:4];
  assign rd_en  = bus.Enable & ~bus.CS_ & ~bus.RD_;
  assign wr_en  = bus.Enable & ~bus.CS_ & ~bus.WR_;
  assign wdata  = Data;
  assign Data   = rd_en ? rdata : {DATA_W{1'bz}};

  // Memory array: not reset, and no writes are captured while Reset is high.
  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  always_ff @(posedge Clk) begin
    if (!Reset && wr_en && !is_reg) begin
      mem_q[addr] <= wdata;
    end
  end

  // Register state
  logic [NCH-1:0]   en_q, en_d, fast_q, fast_d;
  logic [NCH-1:0]   pend_q, pend_d, ovr_q, ovr_d;
  logic [1:0]       ackid_q, ackid_d;
  logic             ackv_q, ackv_d;
  logic             ack_q;
  logic [CNT_W-1:0] reload_q [NCH];
  logic [CNT_W-1:0] reload_d [NCH];
  logic [CNT_W-1:0] cnt_q    [NCH];
  logic [CNT_W-1:0] cnt_d    [NCH];

  logic             ctrl_we, status_we, ack_edge;
  logic [NCH-1:0]   fire, ack_clr, pend_clr, ovr_clr;
  logic [NCH-1:0]   elig_f, elig_n, ack_pool;

  assign ctrl_we   = wr_en & is_reg & (off == 4'h0);
  assign status_we = wr_en & is_reg & (off == 4'h1);
  assign ack_edge  = int_ack & ~ack_q;

  // Only enabled channels can be acknowledged; fast channels go first.
  assign elig_f   = pend_q & en_q & fast_q;
  assign elig_n   = pend_q & en_q & ~fast_q;
  assign ack_pool = (|elig_f) ? elig_f : elig_n;
  assign pend_clr = status_we ? wdata[NCH-1:0]     : '0;
  assign ovr_clr  = status_we ? wdata[2*NCH-1:NCH] : '0;

  always_comb begin
    en_d    = en_q;
    fast_d  = fast_q;
    fire    = '0;
    ack_clr = '0;
    ackid_d = ackid_q;
    ackv_d  = ackv_q;

    if (ctrl_we) begin
      en_d   = wdata[NCH-1:0];
      fast_d = wdata[2*NCH-1:NCH];
    end

    // Timers run on the enable value in effect before this edge.
    for (int ch = 0; ch < NCH; ch++) begin
      reload_d[ch] = reload_q[ch];
      cnt_d[ch]    = cnt_q[ch];
      if (wr_en && is_reg && (off == 4'(4 + ch))) begin
        reload_d[ch] = wdata[CNT_W-1:0];
        cnt_d[ch]    = wdata[CNT_W-1:0];
      end else if (en_q[ch] && (cnt_q[ch] > CNT_W'(1))) begin
        cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
      end else if (en_q[ch] && (cnt_q[ch] == CNT_W'(1))) begin
        cnt_d[ch] = reload_q[ch];
        fire[ch]  = 1'b1;
      end
    end

    // Scan downward so the lowest eligible index is the one that sticks.
    if (ack_edge) begin
      for (int ch = NCH - 1; ch >= 0; ch--) begin
        if (ack_pool[ch]) begin
          ack_clr     = '0;
          ack_clr[ch] = 1'b1;
          ackid_d     = 2'(ch);
          ackv_d      = 1'b1;
        end
      end
    end

    // A fire on the same edge wins over both clear sources.
    pend_d = (pend_q & ~pend_clr & ~ack_clr) | fire;
    ovr_d  = (ovr_q & ~ovr_clr) | (fire & pend_q);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      en_q        <= '0;
      fast_q      <= '0;
      pend_q      <= '0;
      ovr_q       <= '0;
      ackid_q     <= '0;
      ackv_q      <= 1'b0;
      ack_q       <= 1'b0;
      fintr_check <= 1'b0;
      intr_check  <= 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        reload_q[ch] <= '0;
        cnt_q[ch]    <= '0;
      end
    end else begin
      en_q        <= en_d;
      fast_q      <= fast_d;
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
      ackid_q     <= ackid_d;
      ackv_q      <= ackv_d;
      ack_q       <= int_ack;
      // Built from next-state values so a request appears on the edge that
      // sets pending, and a disable or mode change takes effect on its write.
      fintr_check <= |(pend_d & en_d & fast_d);
      intr_check  <= |(pend_d & en_d & ~fast_d);
      for (int ch = 0; ch < NCH; ch++) begin
        reload_q[ch] <= reload_d[ch];
        cnt_q[ch]    <= cnt_d[ch];
      end
    end
  end

  // Combinational read mux
  always_comb begin
    rdata = '0;
    if (!is_reg) begin
      rdata = mem_q[addr];
    end else begin
      case (off)
        4'h0: rdata[2*NCH-1:0] = {fast_q, en_q};
        4'h1: rdata[2*NCH-1:0] = {ovr_q, pend_q};
        4'h2: begin
          rdata[1:0]        = ackid_q;
          rdata[DATA_W-1]   = ackv_q;
        end
        default: ;
      endcase
      for (int ch = 0; ch < NCH; ch++) begin
        if (off == 4'(4 + ch)) rdata[CNT_W-1:0] = reload_q[ch];
        if (off == 4'(8 + ch)) rdata[CNT_W-1:0] = cnt_q[ch];
      end
    end
  end

endmodule

// File: tb/tb_io_intr_timer_dev.sv
module tb_io_intr_timer_dev;

  localparam int ADDR_W = 10;

  localparam logic [9:0] A_CTRL    = 10'h3F0;
  localparam logic [9:0] A_STATUS  = 10'h3F1;
  localparam logic [9:0] A_ACKID   = 10'h3F2;
  localparam logic [9:0] A_UNUSED  = 10'h3F3;
  localparam logic [9:0] A_RELOAD0 = 10'h3F4;
  localparam logic [9:0] A_RELOAD1 = 10'h3F5;
  localparam logic [9:0] A_RELOAD2 = 10'h3F6;
  localparam logic [9:0] A_COUNT0  = 10'h3F8;

  // Clock / reset
  logic Clk     = 1'b0;
  logic Reset   = 1'b1;
  logic int_ack = 1'b0;
  wire  fintr;
  wire  intr;

  always #5 Clk = ~Clk;

  // Data bus: the bench drives it only while tb_oe is high.
  wire  [31:0] data;
  logic [31:0] tb_data = '0;
  logic        tb_oe   = 1'b0;
  assign data = tb_oe ? tb_data : 32'bz;

  io_intr_timer_dev_if #(.ADDR_W(ADDR_W)) bus_if ();

  io_intr_timer_dev dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .bus         (bus_if.slave),
    .Data        (data),
    .int_ack     (int_ack),
    .fintr_check (fintr),
    .intr_check  (intr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Time bound on the whole run
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic bus_idle();
    bus_if.CS_    = 1'b1;
    bus_if.RD_    = 1'b1;
    bus_if.WR_    = 1'b1;
    bus_if.Enable = 1'b1;
    tb_oe         = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic en);
    bus_if.Addr   = a;
    bus_if.Enable = en;
    tb_data       = d;
    tb_oe         = 1'b1;
    bus_if.CS_    = 1'b0;
    bus_if.WR_    = 1'b0;
    step();
    bus_idle();
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] d);
    bus_if.Addr = a;
    bus_if.CS_  = 1'b0;
    bus_if.RD_  = 1'b0;
    #1;
    d = data;
    bus_idle();
  endtask

  task automatic chk_rd(input string tag, input logic [9:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  // Hi-Z probe: the bench drives zero; any device drive would corrupt it.
  task automatic probe(input string tag, input logic [9:0] a, input logic cs, input logic en);
    bus_if.Addr   = a;
    bus_if.CS_    = cs;
    bus_if.RD_    = 1'b0;
    bus_if.Enable = en;
    tb_data       = 32'h0;
    tb_oe         = 1'b1;
    #1;
    chk(tag, data, 32'h0);
    bus_idle();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  logic [31:0] st;

  initial begin
    bus_idle();
    bus_if.Addr = '0;
    do_reset();
    wr(10'd5, 32'hDEADBEEF, 1'b1);

    // 1: reset state
    do_reset();
    chk("rst_fintr", {31'b0, fintr}, 32'h0);
    chk("rst_intr", {31'b0, intr}, 32'h0);
    chk_rd("rst_status", A_STATUS, 32'h0);
    chk_rd("rst_count0", A_COUNT0, 32'h0);
    probe("rst_hiz_cs", 10'd5, 1'b1, 1'b1);

    // 2: memory round trip and Enable gating
    step();
    chk_rd("mem_kept_over_rst", 10'd5, 32'hDEADBEEF);
    wr(10'd5, 32'h12345678, 1'b0);
    chk_rd("mem_en0_ignored", 10'd5, 32'hDEADBEEF);
    probe("hiz_en0", 10'd5, 1'b0, 1'b0);
    wr(10'h3EF, 32'hA5A55A5A, 1'b1);
    chk_rd("mem_top_word", 10'h3EF, 32'hA5A55A5A);
    wr(A_UNUSED, 32'hFFFFFFFF, 1'b1);
    chk_rd("unused_offset", A_UNUSED, 32'h0);

    // 3: ch0 normal, RELOAD 3
    wr(A_RELOAD0, 32'd3, 1'b1);
    chk_rd("reload0_rd", A_RELOAD0, 32'd3);
    chk_rd("count0_load", A_COUNT0, 32'd3);
    wr(A_CTRL, 32'h1, 1'b1);
    chk_rd("ctrl_rd", A_CTRL, 32'h1);
    step();
    step();
    chk("t3_not_yet", {31'b0, intr}, 32'h0);
    step();
    chk("t3_intr_rise", {31'b0, intr}, 32'h1);
    chk_rd("t3_status", A_STATUS, 32'h1);
    chk_rd("t3_count_reload", A_COUNT0, 32'd3);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("t3_ack_intr", {31'b0, intr}, 32'h0);
    chk_rd("t3_ackid", A_ACKID, 32'h80000000);
    chk_rd("t3_status_clr", A_STATUS, 32'h0);
    step();
    step();
    chk("t3_refire", {31'b0, intr}, 32'h1);
    wr(A_CTRL, 32'h0, 1'b1);
    chk("t3_disable_mask", {31'b0, intr}, 32'h0);
    chk_rd("t3_disable_keep", A_STATUS, 32'h1);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk_rd("t3_ack_ineligible", A_STATUS, 32'h1);
    chk_rd("t3_count_hold", A_COUNT0, 32'd2);
    chk_rd("t3_ackid_same", A_ACKID, 32'h80000000);
    wr(A_STATUS, 32'h1, 1'b1);
    chk_rd("t3_w1c", A_STATUS, 32'h0);

    // 4: ch1 fast and ch2 normal, both RELOAD 4
    do_reset();
    wr(A_RELOAD1, 32'd4, 1'b1);
    wr(A_RELOAD2, 32'd4, 1'b1);
    wr(A_CTRL, 32'h26, 1'b1);
    step();
    step();
    step();
    chk("t4_pre_f", {31'b0, fintr}, 32'h0);
    chk("t4_pre_n", {31'b0, intr}, 32'h0);
    step();
    chk("t4_fintr", {31'b0, fintr}, 32'h1);
    chk("t4_intr", {31'b0, intr}, 32'h1);
    chk_rd("t4_status", A_STATUS, 32'h6);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("t4_ack1_f", {31'b0, fintr}, 32'h0);
    chk("t4_ack1_n", {31'b0, intr}, 32'h1);
    chk_rd("t4_ackid1", A_ACKID, 32'h80000001);
    chk_rd("t4_status1", A_STATUS, 32'h4);
    step();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("t4_ack2_n", {31'b0, intr}, 32'h0);
    chk("t4_ack2_f", {31'b0, fintr}, 32'h0);
    chk_rd("t4_ackid2", A_ACKID, 32'h80000002);
    chk_rd("t4_status2", A_STATUS, 32'h0);
    step();
    chk("t4_refire_f", {31'b0, fintr}, 32'h1);
    chk("t4_refire_n", {31'b0, intr}, 32'h1);
    wr(A_CTRL, 32'h06, 1'b1);
    chk("t4_mode_f", {31'b0, fintr}, 32'h0);
    chk("t4_mode_n", {31'b0, intr}, 32'h1);

    // 5: overrun and selective W1C
    do_reset();
    wr(A_RELOAD0, 32'd2, 1'b1);
    wr(A_CTRL, 32'h1, 1'b1);
    step();
    step();
    chk_rd("t5_first", A_STATUS, 32'h01);
    step();
    step();
    chk_rd("t5_overrun", A_STATUS, 32'h11);
    wr(A_STATUS, 32'h10, 1'b1);
    chk_rd("t5_ovr_clr", A_STATUS, 32'h01);
    chk("t5_intr_kept", {31'b0, intr}, 32'h1);

    // 6: fire vs ack, fire vs W1C, reset mid-count
    do_reset();
    wr(A_RELOAD0, 32'd2, 1'b1);
    wr(A_CTRL, 32'h1, 1'b1);
    step();
    step();
    chk("t6_first", {31'b0, intr}, 32'h1);
    step();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("t6_fire_vs_ack", {31'b0, intr}, 32'h1);
    chk_rd("t6_status", A_STATUS, 32'h11);
    chk_rd("t6_ackid", A_ACKID, 32'h80000000);
    step();
    wr(A_STATUS, 32'h1, 1'b1);
    rd(A_STATUS, st);
    chk("t6_fire_vs_w1c", st & 32'h1, 32'h1);
    step();
    do_reset();
    chk_rd("t6_rst_count", A_COUNT0, 32'h0);
    chk_rd("t6_rst_reload", A_RELOAD0, 32'h0);
    chk_rd("t6_rst_ctrl", A_CTRL, 32'h0);
    chk("t6_rst_intr", {31'b0, intr}, 32'h0);
    repeat (6) step();
    chk("t6_quiet_n", {31'b0, intr}, 32'h0);
    chk("t6_quiet_f", {31'b0, fintr}, 32'h0);
    chk_rd("t6_quiet_status", A_STATUS, 32'h0);

    // Report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
